// File: rtl/sp_ram_ctrl_pkg.sv
// sp_ram_ctrl_pkg: shared FSM state type, address-split helpers and byte parity
package sp_ram_ctrl_pkg;

    typedef enum logic {INIT, READY} state_e;

    // Bank index: the word-address bits above the row field.
    function automatic int unsigned bank_of(input int unsigned word_addr, input int unsigned row_w);
        return word_addr >> row_w;
    endfunction

    function automatic int unsigned row_of(input int unsigned word_addr, input int unsigned row_w);
        return word_addr & ((32'd1 << row_w) - 32'd1);
    endfunction

    // Even parity: the stored bit makes the byte plus parity have an even count of ones.
    function automatic logic par_byte(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sp_ram_ctrl_if.sv
// sp_ram_ctrl_if: req/gnt/rvalid memory bus between a requestor (master) and sp_ram_ctrl (slave)
//  req_i/addr_i/we_i/be_i/wdata_i/bypass_en_i : request side, driven by master
//  gnt_o/rvalid_o/rdata_o/err_o/init_done_o   : grant/response side, driven by slave
interface sp_ram_ctrl_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    logic                    req_i;
    logic                    gnt_o;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic                    we_i;
    logic [DATA_WIDTH/8-1:0] be_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    bypass_en_i;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;
    logic                    init_done_o;

    modport master (
        output req_i, addr_i, we_i, be_i, wdata_i, bypass_en_i,
        input  gnt_o, rvalid_o, rdata_o, err_o, init_done_o
    );

    modport slave (
        input  req_i, addr_i, we_i, be_i, wdata_i, bypass_en_i,
        output gnt_o, rvalid_o, rdata_o, err_o, init_done_o
    );
endinterface

// File: rtl/sp_ram_ctrl_bank.sv
// sp_ram_ctrl_bank: one single-port RAM bank with byte-enable writes and registered read
//  clk, en, we, row, be, wdata : access controls, write commits at the clock edge
//  rdata                       : word read on the previous enabled read cycle
//  rpar                        : stored per-byte parity (only with SP_RAM_PARITY_EN)
module sp_ram_ctrl_bank
    import sp_ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WORDS      = 2048
) (
    input  logic                      clk,
    input  logic                      en,
    input  logic                      we,
    input  logic [$clog2(WORDS)-1:0]  row,
    input  logic [DATA_WIDTH/8-1:0]   be,
    input  logic [DATA_WIDTH-1:0]     wdata,
`ifdef SP_RAM_PARITY_EN
    output logic [DATA_WIDTH/8-1:0]   rpar,
`endif
    output logic [DATA_WIDTH-1:0]     rdata
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++)
                    if (be[i]) mem[row][8*i +: 8] <= wdata[8*i +: 8];
            end else begin
                rdata <= mem[row];
            end
        end
    end

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] par [WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < NB; i++)
                    if (be[i]) par[row][i] <= par_byte(wdata[8*i +: 8]);
            end else begin
                rpar <= par[row];
            end
        end
    end
`endif

endmodule

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: multi-bank single-port RAM controller with zero-fill, req/gnt/rvalid and 1/2-cycle read
//  clk   : clock
//  rst_i : synchronous reset, active-high
//  bus   : sp_ram_ctrl_if slave modport (request, grant, response, init_done)
//  Optional SP_RAM_PARITY_EN adds per-byte parity storage and err_o reporting.
module sp_ram_ctrl
    import sp_ram_ctrl_pkg::*;
#(
    parameter int RAM_SIZE   = 32768,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_BANKS  = 4,
    parameter int READ_LAT   = 1,
    parameter int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic         clk,
    input  logic         rst_i,
    sp_ram_ctrl_if.slave bus
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(NB);
    localparam int WPB    = RAM_SIZE / NB / NUM_BANKS;
    localparam int ROW_W  = $clog2(WPB);
    localparam int BANK_W = $clog2(NUM_BANKS);

    state_e                state, state_nxt;
    logic [ROW_W-1:0]      init_cnt;
    logic                  init_wr;
    logic                  grant;
    logic [BANK_W-1:0]     bank_sel;
    logic [ROW_W-1:0]      row_sel;
    logic [NUM_BANKS-1:0]  bank_en;
    logic                  bank_we;
    logic [ROW_W-1:0]      bank_row;
    logic [NB-1:0]         bank_be;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic                  s1_v, s1_we;
    logic [BANK_W-1:0]     s1_bank;
    logic [DATA_WIDTH-1:0] mux_data, rd1;
    logic                  er1;
    logic                  unused_addr;

    assign unused_addr = ^bus.addr_i[OFF-1:0];
    assign bank_sel    = BANK_W'(bank_of(32'(bus.addr_i[ADDR_WIDTH-1:OFF]), ROW_W));
    assign row_sel     = ROW_W'(row_of(32'(bus.addr_i[ADDR_WIDTH-1:OFF]), ROW_W));

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state    <= INIT;
            init_cnt <= '0;
        end else begin
            state    <= state_nxt;
            init_cnt <= (state == INIT) ? init_cnt + 1'b1 : '0;
        end
    end

    // Reset is gated in so a request coinciding with rst_i is neither granted nor written.
    always_comb begin
        state_nxt  = (state == INIT && init_cnt == ROW_W'(WPB - 1)) ? READY : state;
        init_wr    = (state == INIT) && !rst_i;
        grant      = bus.req_i && (state == READY) && !rst_i;
        bank_en    = init_wr ? '1 : grant ? NUM_BANKS'(1) << bank_sel : '0;
        bank_we    = init_wr || (bus.we_i && !bus.bypass_en_i);
        bank_row   = init_wr ? init_cnt : row_sel;
        bank_be    = init_wr ? '1 : bus.be_i;
        bank_wdata = init_wr ? '0 : bus.wdata_i;
    end

    assign bus.gnt_o       = grant;
    assign bus.init_done_o = (state == READY);

`ifdef SP_RAM_PARITY_EN
    logic [NB-1:0] bank_rpar [NUM_BANKS];
    logic [NB-1:0] calc_par;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        sp_ram_ctrl_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .WORDS      (WPB)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (bank_we),
            .row   (bank_row),
            .be    (bank_be),
            .wdata (bank_wdata),
`ifdef SP_RAM_PARITY_EN
            .rpar  (bank_rpar[b]),
`endif
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            s1_v    <= 1'b0;
            s1_we   <= 1'b0;
            s1_bank <= '0;
        end else begin
            s1_v    <= grant;
            s1_we   <= bus.we_i;
            s1_bank <= bank_sel;
        end
    end

    // Write responses return zero data; the macro output is only meaningful for reads.
    assign mux_data = bank_rdata[s1_bank];
    assign rd1      = (s1_v && !s1_we) ? mux_data : '0;

`ifdef SP_RAM_PARITY_EN
    always_comb begin
        calc_par = '0;
        for (int i = 0; i < NB; i++) calc_par[i] = par_byte(mux_data[8*i +: 8]);
    end
    assign er1 = s1_v && !s1_we && (calc_par != bank_rpar[s1_bank]);
`else
    assign er1 = 1'b0;
`endif

    if (READ_LAT == 2) begin : g_lat2
        logic                  s2_v, s2_err;
        logic [DATA_WIDTH-1:0] s2_rdata;
        always_ff @(posedge clk) begin
            if (rst_i) begin
                s2_v     <= 1'b0;
                s2_rdata <= '0;
                s2_err   <= 1'b0;
            end else begin
                s2_v     <= s1_v;
                s2_rdata <= rd1;
                s2_err   <= er1;
            end
        end
        assign bus.rvalid_o = s2_v;
        assign bus.rdata_o  = s2_rdata;
        assign bus.err_o    = s2_err;
    end else begin : g_lat1
        assign bus.rvalid_o = s1_v;
        assign bus.rdata_o  = rd1;
        assign bus.err_o    = er1;
    end

endmodule
